// File: rtl/cache_write_buffer.sv
// Write-through store buffer between the data cache and memory: queues stores,
// drains them in order, and serves line-fill reads with forwarding from pending stores.
module cache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          buf_empty,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [PW-1:0]    head, tail, fwd_idx;
    logic [CW-1:0]    count, count_nxt;
    state_t           state;
    logic             push, retire, full, fwd_hit;
    logic [DW-1:0]    fwd_data;

    // wr_ready is registered, so a store offered while full is never taken,
    // even in the cycle an ack frees a slot.
    assign push   = wr_req && wr_ready;
    assign retire = (state == DRAIN) && mem_ack;
    assign full   = (count == CW'(DEPTH));

    always_comb begin
        count_nxt = count;
        if (push && !retire)
            count_nxt = count + 1'b1;
        else if (!push && retire)
            count_nxt = count - 1'b1;
    end

    // Walk oldest to youngest so the last hit is the youngest; a same-cycle store wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (ent_vld[fwd_idx] && ent_addr[fwd_idx][AW-1:2] == rd_addr[AW-1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[fwd_idx];
            end
        end
        if (push && wr_addr[AW-1:2] == rd_addr[AW-1:2]) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= wr_addr;
            ent_data[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld   <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            wr_ready  <= 1'b0;
            buf_empty <= 1'b1;
        end else begin
            if (retire) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (push) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            count     <= count_nxt;
            wr_ready  <= (count_nxt < CW'(DEPTH));
            buf_empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req && fwd_hit) begin
                        rd_data  <= fwd_data;
                        rd_valid <= 1'b1;
                        state    <= RESP;
                    end else if (rd_req && !full) begin
                        // Misses may bypass queued stores: their addresses cannot overlap.
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= rd_addr;
                        state    <= READ;
                    end else if (count != '0) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= ent_addr[head];
                        mem_wdata <= ent_data[head];
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        rd_data  <= mem_rdata;
                        rd_valid <= 1'b1;
                        state    <= RESP;
                    end
                end
                default: begin
                    rd_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_write_buffer.sv
// Scoreboard bench for cache_write_buffer: a memory responder checks drained
// stores against queued expectations; read data is checked as rd_valid pulses.
module tb_cache_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          buf_empty;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];
    logic          log_we[$];
    logic [AW-1:0] log_addr[$];

    logic          ack_en = 1'b0;
    logic          ack_once = 1'b0;
    int            ack_delay = 0;
    int            wait_cnt = 0;
    logic [DW-1:0] rdata_model = '0;
    logic          rd_mem_seen = 1'b0;

    cache_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .buf_empty(buf_empty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after ack_delay waiting cycles, checks drained stores.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mem_req && !mem_we) rd_mem_seen = 1'b1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (rst_n && mem_req && (ack_en || ack_once)) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_model;
                    wait_cnt  = 0;
                    ack_once  = 1'b0;
                    log_we.push_back(mem_we);
                    log_addr.push_back(mem_addr);
                    if (mem_we) begin
                        n_cmp++;
                        if (exp_wr.size() == 0) begin
                            n_bad++;
                            $display("FAIL mem_write_unexpected: addr=%h data=%h, required no write", mem_addr, mem_wdata);
                        end else begin
                            e = exp_wr.pop_front();
                            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                                n_bad++;
                                $display("FAIL mem_write_order: got %h=%h, required %h=%h", mem_addr, mem_wdata, e.addr, e.data);
                            end
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        while (!wr_ready && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        n_cmp++;
        if (!wr_ready) begin
            n_bad++;
            $display("FAIL store_accept_timeout: addr=%h never accepted, required acceptance", a);
        end else begin
            exp_wr.push_back('{addr: a, data: d});
        end
        @(posedge clk); @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic wait_rd(input int budget, output int lat);
        lat = 0;
        while (!rd_valid && lat < budget) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        if (!rd_valid) lat = -1;
    endtask

    task automatic wait_empty(input int budget, input string tag);
        int n = 0;
        while ((!buf_empty || mem_req || exp_wr.size() != 0) && n < budget) begin
            @(posedge clk); @(negedge clk); n++;
        end
        n_cmp++;
        if (!buf_empty || exp_wr.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: buf_empty=%b pending=%0d, required 1 and 0", tag, buf_empty, exp_wr.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({wr_ready, rd_valid, mem_req, mem_we, buf_empty} !== 5'b00001) begin
            n_bad++;
            $display("FAIL reset_flags: {wr_ready,rd_valid,mem_req,mem_we,buf_empty}=%b, required 00001",
                     {wr_ready, rd_valid, mem_req, mem_we, buf_empty});
        end
        n_cmp++;
        if (rd_data !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_data: rd_data=%h mem_addr=%h mem_wdata=%h, required all 0", rd_data, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_wr_ready_rise: wr_ready=%b, required 1", wr_ready);
        end
    endtask

    task automatic test_fill_and_drain;
        ack_en = 1'b0; ack_delay = 0;
        log_we.delete(); log_addr.delete();
        for (int i = 0; i < 4; i++) do_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_wr_ready: wr_ready=%b, required 0", wr_ready);
        end
        wr_req = 1'b1; wr_addr = 32'h110; wr_data = 32'hA4;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (wr_ready !== 1'b0 || buf_empty !== 1'b0) begin
                n_bad++;
                $display("FAIL fifth_store_stall: wr_ready=%b buf_empty=%b, required 0 0", wr_ready, buf_empty);
            end
        end
        wr_req = 1'b0;
        ack_en = 1'b1;
        wait_empty(40, "fill");
        n_cmp++;
        if (log_we.size() != 4) begin
            n_bad++;
            $display("FAIL fill_write_count: %0d memory writes, required 4", log_we.size());
        end
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_wr_ready_after: wr_ready=%b, required 1", wr_ready);
        end
    endtask

    task automatic test_forward_hit;
        int lat;
        ack_en = 1'b0; ack_delay = 0;
        rd_mem_seen = 1'b0;
        wr_req = 1'b1; wr_addr = 32'h200; wr_data = 32'h11;
        exp_wr.push_back('{addr: 32'h200, data: 32'h11});
        @(posedge clk); @(negedge clk);
        // Second store to the same word goes in alongside the read request.
        wr_data = 32'h22;
        exp_wr.push_back('{addr: 32'h200, data: 32'h22});
        rd_req = 1'b1; rd_addr = 32'h200;
        exp_rd.push_back(32'h22);
        @(posedge clk); @(negedge clk);
        wr_req = 1'b0;
        wait_rd(10, lat);
        n_cmp++;
        if (lat < 0 || lat + 1 > 2) begin
            n_bad++;
            $display("FAIL fwd_latency: %0d edges, required <= 2", lat < 0 ? -1 : lat + 1);
        end
        if (lat >= 0) begin
            n_cmp++;
            if (rd_data !== exp_rd[0]) begin
                n_bad++;
                $display("FAIL fwd_data: rd_data=%h, required %h", rd_data, exp_rd[0]);
            end
        end
        void'(exp_rd.pop_front());
        rd_req = 1'b0;
        ack_en = 1'b1;
        wait_empty(40, "fwd");
        n_cmp++;
        if (rd_mem_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL fwd_no_mem_read: memory read seen=%b, required 0", rd_mem_seen);
        end
    endtask

    task automatic test_read_bypass;
        int lat;
        ack_en = 1'b0;
        log_we.delete(); log_addr.delete();
        do_store(32'h300, 32'h5);
        rd_req = 1'b1; rd_addr = 32'h400;
        exp_rd.push_back(32'hDEAD);
        rdata_model = 32'hDEAD; ack_delay = 3; ack_en = 1'b1;
        wait_rd(30, lat);
        n_cmp++;
        if (lat < 0 || rd_data !== exp_rd[0]) begin
            n_bad++;
            $display("FAIL bypass_data: rd_data=%h lat=%0d, required %h", rd_data, lat, exp_rd[0]);
        end
        void'(exp_rd.pop_front());
        rd_req = 1'b0;
        wait_empty(40, "bypass");
        n_cmp++;
        if (log_we.size() != 2 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h400 ||
            log_we[1] !== 1'b1 || log_addr[1] !== 32'h300) begin
            n_bad++;
            $display("FAIL bypass_order: %0d transactions, first we=%b addr=%h, required read 400 then write 300",
                     log_we.size(), log_we.size() > 0 ? log_we[0] : 1'bx, log_addr.size() > 0 ? log_addr[0] : 'x);
        end
    endtask

    task automatic test_full_miss;
        int lat;
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) do_store(32'h700 + 32'(4 * i), 32'hB0 + 32'(i));
        log_we.delete(); log_addr.delete();
        rd_req = 1'b1; rd_addr = 32'h500;
        exp_rd.push_back(32'hBEEF);
        rdata_model = 32'hBEEF; ack_delay = 1; ack_en = 1'b1;
        wait_rd(40, lat);
        n_cmp++;
        if (lat < 0 || log_we.size() != 2 || log_we[0] !== 1'b1 || log_addr[0] !== 32'h700 ||
            log_we[1] !== 1'b0 || log_addr[1] !== 32'h500) begin
            n_bad++;
            $display("FAIL full_miss_order: lat=%0d transactions=%0d before rd_valid, required write 700 then read 500",
                     lat, log_we.size());
        end
        n_cmp++;
        if (rd_data !== exp_rd[0]) begin
            n_bad++;
            $display("FAIL full_miss_data: rd_data=%h, required %h", rd_data, exp_rd[0]);
        end
        void'(exp_rd.pop_front());
        rd_req = 1'b0;
        wait_empty(60, "full_miss");
    endtask

    task automatic test_push_on_ack_full;
        ack_en = 1'b0; ack_delay = 0;
        for (int i = 0; i < 4; i++) do_store(32'h600 + 32'(4 * i), 32'hE0 + 32'(i));
        wr_req = 1'b1; wr_addr = 32'h610; wr_data = 32'hE4;
        ack_once = 1'b1;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_push_blocked: wr_ready=%b, required 0", wr_ready);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ack_push_next: wr_ready=%b, required 1", wr_ready);
        end
        exp_wr.push_back('{addr: 32'h610, data: 32'hE4});
        @(posedge clk); @(negedge clk);
        wr_req = 1'b0;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_push_refull: wr_ready=%b, required 0", wr_ready);
        end
        ack_en = 1'b1;
        wait_empty(60, "wrap");
    endtask

    task automatic test_reset_in_drain;
        int n = 0;
        ack_en = 1'b0;
        do_store(32'h800, 32'h77);
        while (!mem_req && n < 10) begin
            @(posedge clk); @(negedge clk); n++;
        end
        n_cmp++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_drain_entry: mem_req=%b mem_we=%b, required 1 1", mem_req, mem_we);
        end
        rst_n = 1'b0;
        #1;
        exp_wr.delete();
        n_cmp++;
        if (mem_req !== 1'b0 || buf_empty !== 1'b1 || wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_drain_async: mem_req=%b buf_empty=%b wr_ready=%b, required 0 1 0", mem_req, buf_empty, wr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_release_wr_ready_early: wr_ready=%b, required 0", wr_ready);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (wr_ready !== 1'b1 || buf_empty !== 1'b1 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_release: wr_ready=%b buf_empty=%b mem_req=%b, required 1 1 0", wr_ready, buf_empty, mem_req);
        end
    endtask

    initial begin
        test_reset;
        test_fill_and_drain;
        test_forward_hit;
        test_read_bypass;
        test_full_miss;
        test_push_on_ack_full;
        test_reset_in_drain;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_write_buffer.md
Name: cache_write_buffer

Overview:
- Sits between the 8-way write-through data cache and main memory, and owns the memory port.
- Absorbs cache write-through stores into a small FIFO and drains them to memory in order.
- Serves cache line-fill reads, forwarding from the buffer when the address is pending there, so the cache never stalls on a store and never reads stale memory.

Parameters:
DEPTH, 4, number of buffered stores (power of two, >=2)
AW, 32, address width
DW, 32, data width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
wr_req  input  1  cache presents a store; held until accepted
wr_addr  input  AW  store address
wr_data  input  DW  store data
wr_ready  output  1  buffer can accept a store this cycle
rd_req  input  1  cache requests a line fill; held until rd_valid
rd_addr  input  AW  fill address
rd_valid  output  1  one-cycle pulse, rd_data valid
rd_data  output  DW  fill data
buf_empty  output  1  no stores pending (fence/drain indication)
mem_req  output  1  memory transaction request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_ack  input  1  memory completes the transaction, one-cycle pulse
mem_rdata  input  DW  memory read data, valid with mem_ack

Behaviour:
- Reset (async, rst_n=0): all entries invalid; head, tail and count = 0; FSM = IDLE; wr_ready=0; rd_valid=0; rd_data=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; buf_empty=1.
- After reset: wr_ready goes to 1 on the first clk edge after rst_n rises.
- Reset mid-transaction: mem_req drops immediately, and buffered stores are discarded.
- Store accept: occurs when wr_req && wr_ready at a clock edge. The entry is written at tail, tail wraps modulo DEPTH, and count increments.
- wr_ready: registered; wr_ready = (next count < DEPTH).
- When full, wr_ready=0 and wr_req is ignored; the requester holds it.
- Simultaneous push and drain-complete: count is unchanged. A push arriving while full is not accepted that cycle, even if an ack retires the head.
- Stores are not merged: a repeated address is appended as a new entry.
- Address matching compares addr[AW-1:2] (word granularity).
- FSM states: IDLE, DRAIN, READ, RESP.
- IDLE priority:
  - If rd_req is pending and forward-hit -> RESP; rd_data = youngest matching entry.
  - If rd_req is pending, forward-miss and buffer not full -> READ.
  - If not empty -> DRAIN.
  - A read miss waits for DRAIN only when the buffer is full.
- DRAIN: mem_req=1, mem_we=1, addr/wdata = head entry, held stable until mem_ack.
- On mem_ack in DRAIN: the head is retired and the FSM returns to IDLE. The minimum is 2 cycles per store. The head stays valid for forwarding until retired.
- READ: mem_req=1, mem_we=0, mem_addr=rd_addr. On mem_ack, rd_data <= mem_rdata -> RESP.
- RESP: rd_valid=1 for exactly one cycle -> IDLE. A new rd_req is considered the cycle after RESP.
- Forward-hit latency is 2 edges from rd_req (IDLE decision, RESP pulse). Miss latency is mem latency + 2.
- Forwarding includes a store accepted in the same cycle as the IDLE decision; wr_data wins over older entries.
- mem_req is low in IDLE and RESP; mem_ack outside DRAIN/READ is ignored.
- buf_empty is registered and equals (count==0).
- Read-after-write ordering: a read hitting the buffer never reaches memory. A read missing the buffer may bypass pending stores (the addresses are disjoint).

Test Plan:
- Reset then 4 stores (0x100..0x10C, data 0xA0..0xA3) with mem_ack held low -> wr_ready=0 after the 4th, 5th store stalls; release ack each cycle -> memory sees writes in order 0x100..0x10C, buf_empty=1 after the 4th ack.
- Store 0x200=0x11, then 0x200=0x22, ack low; rd_req 0x200 -> rd_valid after 2 edges, rd_data=0x22, mem_req never asserted with mem_we=0.
- Buffer holds 0x300=0x5 (not full); rd_req 0x400, mem_rdata=0xDEAD with ack 3 cycles later -> mem_we=0 read issued before the drain, rd_data=0xDEAD, then the 0x300 drain follows.
- Buffer full, rd_req miss 0x500 -> the head store drains first, then the read; rd_valid only after the read ack.
- Full buffer with mem_ack and wr_req in the same cycle -> store not accepted that cycle, accepted next; count stays <= DEPTH, tail wraps to entry 0 correctly.
- Assert rst_n=0 while in DRAIN with mem_req=1 -> mem_req=0 immediately, buf_empty=1, wr_ready=0, then wr_ready=1 one edge after release.
